// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame sequencer: HEADER, CMD, LEN, payload, CHK (XOR of CMD, LEN, payload).
// Buffers the payload and releases it on a valid/ready byte stream only after a good checksum.
module uart_rx_frame_ctrl #(
  parameter int unsigned CLK_FRE    = 50,
  parameter logic [7:0]  HEADER     = 8'hA5,
  parameter int unsigned MAX_LEN    = 16,
  parameter int unsigned TIMEOUT_US = 1000
) (
  input  logic       i_clk_sys,
  input  logic       i_rst_n,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_done,
  output logic [7:0] o_cmd,
  output logic [7:0] o_len,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_last,
  output logic       o_frame_err,
  output logic [1:0] o_err_code,
  output logic       o_busy,
  output logic [7:0] o_drop_cnt
);

  localparam int unsigned PTR_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned DEPTH   = 1 << PTR_W;
  localparam int unsigned TMO_CYC = CLK_FRE * TIMEOUT_US;
  localparam int unsigned TMR_W   = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TMO_CYC - 1);
  localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  localparam logic [1:0] ERR_CHK = 2'b01;
  localparam logic [1:0] ERR_LEN = 2'b10;
  localparam logic [1:0] ERR_TMO = 2'b11;

  typedef enum logic [2:0] {
    S_HUNT, S_CMD, S_LEN, S_PAYLOAD, S_CHK, S_OUT
  } state_t;

  state_t           state;
  logic [7:0]       buffer [DEPTH];
  logic [7:0]       wptr;
  logic [7:0]       rptr;
  logic [7:0]       rptr_nxt;
  logic [7:0]       chk;
  logic [TMR_W-1:0] timer;
  logic             in_frame;
  logic             expired;

  assign in_frame = state inside {S_CMD, S_LEN, S_PAYLOAD, S_CHK};
  // NOTE: a byte strobe in the expiry cycle takes precedence, so it is excluded here.
  assign expired  = in_frame && !i_rx_done && (timer == TMR_LIMIT);
  assign rptr_nxt = rptr + 8'd1;
  assign o_busy   = (state != S_HUNT);

  // NOTE: the payload buffer is deliberately not reset; it is only ever read at
  // indices written earlier in the same frame.
  always_ff @(posedge i_clk_sys) begin
    if (state == S_PAYLOAD && i_rx_done) buffer[wptr[PTR_W-1:0]] <= i_rx_data;
  end

  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n)                                timer <= '0;
    else if (!in_frame || i_rx_done || expired)  timer <= '0;
    else                                         timer <= timer + TMR_ONE;
  end

  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_HUNT;
      wptr        <= '0;
      rptr        <= '0;
      chk         <= '0;
      o_cmd       <= '0;
      o_len       <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_last      <= 1'b0;
      o_frame_err <= 1'b0;
      o_err_code  <= '0;
      o_drop_cnt  <= '0;
    end else begin
      o_frame_err <= 1'b0;
      if (expired) begin
        state       <= S_HUNT;
        o_frame_err <= 1'b1;
        o_err_code  <= ERR_TMO;
        wptr        <= '0;
        chk         <= '0;
      end else begin
        case (state)
          S_HUNT: begin
            if (i_rx_done && i_rx_data == HEADER) begin
              state <= S_CMD;
              wptr  <= '0;
              chk   <= '0;
            end
          end
          S_CMD: begin
            if (i_rx_done) begin
              o_cmd <= i_rx_data;
              chk   <= i_rx_data;
              state <= S_LEN;
            end
          end
          S_LEN: begin
            if (i_rx_done) begin
              o_len <= i_rx_data;
              chk   <= chk ^ i_rx_data;
              if (i_rx_data > MAX_LEN_B) begin
                state       <= S_HUNT;
                o_frame_err <= 1'b1;
                o_err_code  <= ERR_LEN;
                wptr        <= '0;
                chk         <= '0;
              end else if (i_rx_data == 8'd0) begin
                state <= S_CHK;
              end else begin
                state <= S_PAYLOAD;
              end
            end
          end
          S_PAYLOAD: begin
            if (i_rx_done) begin
              wptr <= wptr + 8'd1;
              chk  <= chk ^ i_rx_data;
              if (wptr + 8'd1 == o_len) state <= S_CHK;
            end
          end
          S_CHK: begin
            if (i_rx_done) begin
              if (i_rx_data == chk) begin
                state   <= S_OUT;
                rptr    <= '0;
                o_valid <= 1'b1;
                o_data  <= (o_len == 8'd0) ? 8'h00 : buffer[0];
                o_last  <= (o_len <= 8'd1);
              end else begin
                state       <= S_HUNT;
                o_frame_err <= 1'b1;
                o_err_code  <= ERR_CHK;
                wptr        <= '0;
                chk         <= '0;
              end
            end
          end
          S_OUT: begin
            // Bytes arriving while the frame drains are discarded but counted.
            if (i_rx_done && o_drop_cnt != 8'hFF) o_drop_cnt <= o_drop_cnt + 8'd1;
            if (o_valid && i_ready) begin
              if (o_last) begin
                o_valid <= 1'b0;
                o_last  <= 1'b0;
                state   <= S_HUNT;
              end else begin
                rptr   <= rptr_nxt;
                o_data <= buffer[rptr_nxt[PTR_W-1:0]];
                o_last <= (rptr + 8'd2 == o_len);
              end
            end
          end
          default: state <= S_HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl; timeout shortened to 2 us (100 cycles, expiry at timer 99)
// so boundary cases run quickly.
module tb_uart_rx_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       ready;
  logic [7:0] cmd, len, data, drop_cnt;
  logic       valid, last, frame_err, busy;
  logic [1:0] err_code;

  int n_cmp = 0;
  int n_err = 0;

  logic [8:0] beats [$];
  int   err_pulses   = 0;
  int   valid_cycles = 0;
  int   hold_viol    = 0;
  logic       prev_v = 1'b0;
  logic       prev_r = 1'b0;
  logic       prev_l = 1'b0;
  logic [7:0] prev_d = 8'h00;

  uart_rx_frame_ctrl #(
    .CLK_FRE(50), .HEADER(8'hA5), .MAX_LEN(16), .TIMEOUT_US(2)
  ) dut (
    .i_clk_sys(clk), .i_rst_n(rst_n), .i_rx_data(rx_data), .i_rx_done(rx_done),
    .o_cmd(cmd), .o_len(len), .o_data(data), .o_valid(valid), .i_ready(ready),
    .o_last(last), .o_frame_err(frame_err), .o_err_code(err_code),
    .o_busy(busy), .o_drop_cnt(drop_cnt)
  );

  always #10 clk = ~clk;

  // Observe on the falling edge; a beat seen here is accepted at the next rising edge.
  always @(negedge clk) begin
    if (valid && ready) beats.push_back({last, data});
    if (frame_err) err_pulses <= err_pulses + 1;
    if (valid) valid_cycles <= valid_cycles + 1;
    if (prev_v && !prev_r && (valid !== 1'b1 || data !== prev_d || last !== prev_l))
      hold_viol <= hold_viol + 1;
    prev_v <= valid;
    prev_r <= ready;
    prev_d <= data;
    prev_l <= last;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b0, e0, v0, h0;
    rst_n   = 1'b0;
    rx_done = 1'b0;
    rx_data = 8'h00;
    ready   = 1'b1;
    #15;
    check("rst_valid",    32'(valid),     0);
    check("rst_data",     32'(data),      0);
    check("rst_cmd",      32'(cmd),       0);
    check("rst_len",      32'(len),       0);
    check("rst_last",     32'(last),      0);
    check("rst_err",      32'(frame_err), 0);
    check("rst_err_code", 32'(err_code),  0);
    check("rst_busy",     32'(busy),      0);
    check("rst_drop",     32'(drop_cnt),  0);
    rst_n = 1'b1;
    tick();

    // Good two-byte frame, consumer always ready
    b0 = beats.size(); e0 = err_pulses;
    send(8'hA5); send(8'h01); send(8'h02); send(8'h10); send(8'h20); send(8'h33);
    check("good_valid_lat", 32'(valid), 1);
    check("good_first_data", 32'(data), 32'h10);
    check("good_first_last", 32'(last), 0);
    idle(4);
    check("good_nbeats", beats.size() - b0, 2);
    check("good_beat0", 32'(beats[b0]),   {23'd0, 1'b0, 8'h10});
    check("good_beat1", 32'(beats[b0+1]), {23'd0, 1'b1, 8'h20});
    check("good_cmd", 32'(cmd), 32'h01);
    check("good_len", 32'(len), 32'h02);
    check("good_no_err", err_pulses - e0, 0);
    check("good_idle_busy", 32'(busy), 0);

    // Same frame with a wrong checksum
    e0 = err_pulses; v0 = valid_cycles;
    send(8'hA5); send(8'h01); send(8'h02); send(8'h10); send(8'h20); send(8'h34);
    check("chk_err_pulse", 32'(frame_err), 1);
    check("chk_err_code", 32'(err_code), 32'h1);
    check("chk_busy", 32'(busy), 0);
    tick();
    check("chk_err_one_cycle", 32'(frame_err), 0);
    idle(2);
    check("chk_err_count", err_pulses - e0, 1);
    check("chk_no_valid", valid_cycles - v0, 0);

    // LEN above MAX_LEN, then a zero-length frame
    e0 = err_pulses; b0 = beats.size();
    send(8'hA5); send(8'h07); send(8'h11);
    check("len_err_pulse", 32'(frame_err), 1);
    check("len_err_code", 32'(err_code), 32'h2);
    check("len_busy", 32'(busy), 0);
    send(8'hA5); send(8'h07); send(8'h00); send(8'h07);
    check("zero_valid", 32'(valid), 1);
    check("zero_data", 32'(data), 32'h00);
    check("zero_last", 32'(last), 1);
    idle(3);
    check("zero_nbeats", beats.size() - b0, 1);
    check("zero_beat", 32'(beats[b0]), {23'd0, 1'b1, 8'h00});
    check("zero_cmd", 32'(cmd), 32'h07);
    check("zero_len", 32'(len), 32'h00);
    check("len_err_count", err_pulses - e0, 1);

    // Inter-byte timeout inside a frame
    e0 = err_pulses;
    send(8'hA5); send(8'h01);
    idle(110);
    check("tmo_err_count", err_pulses - e0, 1);
    check("tmo_err_code", 32'(err_code), 32'h3);
    check("tmo_busy", 32'(busy), 0);

    // No byte for 100 cycles after HEADER: error fires on the 100th
    send(8'hA5);
    idle(100);
    check("tmo_edge_err", 32'(frame_err), 1);
    check("tmo_edge_busy", 32'(busy), 0);
    idle(2);

    // Byte lands in the expiry cycle: processed, no timeout
    e0 = err_pulses; b0 = beats.size();
    send(8'hA5);
    idle(99);
    send(8'h02);
    check("exp_byte_busy", 32'(busy), 1);
    check("exp_byte_cmd", 32'(cmd), 32'h02);
    send(8'h00); send(8'h02);
    check("exp_frame_valid", 32'(valid), 1);
    idle(3);
    check("exp_no_err", err_pulses - e0, 0);
    check("exp_nbeats", beats.size() - b0, 1);
    check("exp_err_code_held", 32'(err_code), 32'h3);

    // Backpressure while three stray bytes arrive
    b0 = beats.size(); h0 = hold_viol;
    ready = 1'b0;
    send(8'hA5); send(8'h03); send(8'h03); send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    check("bp_valid", 32'(valid), 1);
    check("bp_data_first", 32'(data), 32'hAA);
    send(8'h11); send(8'hA5); send(8'h22);
    idle(7);
    check("bp_valid_held", 32'(valid), 1);
    check("bp_data_held", 32'(data), 32'hAA);
    check("bp_drop_cnt", 32'(drop_cnt), 3);
    check("bp_busy", 32'(busy), 1);
    ready = 1'b1;
    idle(5);
    check("bp_hold_viol", hold_viol - h0, 0);
    check("bp_nbeats", beats.size() - b0, 3);
    check("bp_beat0", 32'(beats[b0]),   {23'd0, 1'b0, 8'hAA});
    check("bp_beat1", 32'(beats[b0+1]), {23'd0, 1'b0, 8'hBB});
    check("bp_beat2", 32'(beats[b0+2]), {23'd0, 1'b1, 8'hCC});
    check("bp_done_busy", 32'(busy), 0);

    // Asynchronous reset in the middle of a payload
    send(8'hA5); send(8'h05); send(8'h02); send(8'h01);
    check("mid_busy_before", 32'(busy), 1);
    rst_n = 1'b0;
    #3;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_cmd", 32'(cmd), 0);
    check("mid_rst_len", 32'(len), 0);
    check("mid_rst_valid", 32'(valid), 0);
    check("mid_rst_drop", 32'(drop_cnt), 0);
    check("mid_rst_err_code", 32'(err_code), 0);
    #3;
    rst_n = 1'b1;
    tick();
    b0 = beats.size();
    send(8'hA5); send(8'h09); send(8'h01); send(8'h5A); send(8'h52);
    check("post_rst_valid", 32'(valid), 1);
    check("post_rst_data", 32'(data), 32'h5A);
    check("post_rst_last", 32'(last), 1);
    check("post_rst_cmd", 32'(cmd), 32'h09);
    idle(3);
    check("post_rst_nbeats", beats.size() - b0, 1);
    check("post_rst_beat", 32'(beats[b0]), {23'd0, 1'b1, 8'h5A});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
